// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing presets, scan-region encoding and helpers for the VGA timing engine
package vga_pkg;

  typedef enum logic [1:0] {
    REG_SYNC   = 2'd0,
    REG_BP     = 2'd1,
    REG_ACTIVE = 2'd2,
    REG_FP     = 2'd3
  } scan_region_e;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    bit          hs_pol;
    bit          vs_pol;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_60  = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  localparam vga_timing_t VGA_800X600_60  = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};
  localparam vga_timing_t VGA_1024X768_60 = '{1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, 1'b0};

  function automatic int vga_total(input int sync_w, input int bp_w, input int active_w, input int fp_w);
    return sync_w + bp_w + active_w + fp_w;
  endfunction

endpackage

// File: rtl/vga_scan_counter.sv
// rtl/vga_scan_counter.sv - x/y scan counters, whole-frame run control and region decode
module vga_scan_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter int X_W      = 11,
  parameter int Y_W      = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic               running,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output scan_region_e       h_region,
  output scan_region_e       v_region,
  output logic               frame_start
);

  localparam int H_TOTAL = vga_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int V_TOTAL = vga_total(V_SYNC, V_BP, V_ACTIVE, V_FP);

  localparam logic [X_W:0] H_LAST      = (X_W+1)'(H_TOTAL - 1);
  localparam logic [X_W:0] H_BP_START  = (X_W+1)'(H_SYNC);
  localparam logic [X_W:0] H_ACT_START = (X_W+1)'(H_SYNC + H_BP);
  localparam logic [X_W:0] H_FP_START  = (X_W+1)'(H_TOTAL - H_FP);
  localparam logic [Y_W:0] V_LAST      = (Y_W+1)'(V_TOTAL - 1);
  localparam logic [Y_W:0] V_BP_START  = (Y_W+1)'(V_SYNC);
  localparam logic [Y_W:0] V_ACT_START = (Y_W+1)'(V_SYNC + V_BP);
  localparam logic [Y_W:0] V_FP_START  = (Y_W+1)'(V_TOTAL - V_FP);

  logic [X_W:0] xe;
  logic [Y_W:0] ye;
  logic         line_end;
  logic         frame_end;

  assign xe          = {1'b0, x};
  assign ye          = {1'b0, y};
  assign line_end    = (xe == H_LAST);
  assign frame_end   = line_end && (ye == V_LAST);
  assign frame_start = running && (x == '0) && (y == '0);

  // en only matters while idle or on the very last pixel of a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      x       <= '0;
      y       <= '0;
    end else if (!running) begin
      x       <= '0;
      y       <= '0;
      running <= en;
    end else if (line_end) begin
      x <= '0;
      if (frame_end) begin
        y       <= '0;
        running <= en;
      end else begin
        y <= y + 1'b1;
      end
    end else begin
      x <= x + 1'b1;
    end
  end

  always_comb begin
    h_region = REG_FP;
    if (xe < H_BP_START)       h_region = REG_SYNC;
    else if (xe < H_ACT_START) h_region = REG_BP;
    else if (xe < H_FP_START)  h_region = REG_ACTIVE;
  end

  always_comb begin
    v_region = REG_FP;
    if (ye < V_BP_START)       v_region = REG_SYNC;
    else if (ye < V_ACT_START) v_region = REG_BP;
    else if (ye < V_FP_START)  v_region = REG_ACTIVE;
  end

endmodule

// File: rtl/vga_timing_engine.sv
// rtl/vga_timing_engine.sv - parametrised VGA timing generator with pixel-fetch handshake
module vga_timing_engine
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = 1024,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BP      = 160,
  parameter int V_ACTIVE  = 768,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 29,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int R_W       = 5,
  parameter int G_W       = 6,
  parameter int B_W       = 5,
  parameter int REQ_LEAD  = 1,
  parameter int FSYNC_CYC = 4,
  localparam int PIX_W    = R_W + G_W + B_W,
  localparam int X_W      = $clog2(vga_total(H_SYNC, H_BP, H_ACTIVE, H_FP)),
  localparam int Y_W      = $clog2(vga_total(V_SYNC, V_BP, V_ACTIVE, V_FP))
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  input  logic             din_valid,
  output logic             data_req,
  output logic             frame_sync,
  output logic             data_lock,
  output logic             underflow,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic             vga_de,
  output logic [X_W-1:0]   pixel_x,
  output logic [Y_W-1:0]   pixel_y,
  output logic [R_W-1:0]   vga_red,
  output logic [G_W-1:0]   vga_green,
  output logic [B_W-1:0]   vga_blue
);

  localparam logic [X_W:0]   REQ_LO  = (X_W+1)'(H_SYNC + H_BP);
  localparam logic [X_W:0]   REQ_HI  = (X_W+1)'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [X_W:0]   LEAD    = (X_W+1)'(REQ_LEAD);
  localparam logic [X_W-1:0] X0      = X_W'(H_SYNC + H_BP);
  localparam logic [Y_W-1:0] Y0      = Y_W'(V_SYNC + V_BP);
  localparam int             FS_W    = $clog2(FSYNC_CYC + 1);
  localparam logic [FS_W-1:0] FS_LOAD = FS_W'(FSYNC_CYC - 1);

  logic               running;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  scan_region_e       h_region;
  scan_region_e       v_region;
  logic               frame_start;
  logic [X_W:0]       x_lead;
  logic               line_on;
  logic               pix_on;
  logic [FS_W-1:0]    fs_cnt;

  vga_scan_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .X_W      (X_W),
    .Y_W      (Y_W)
  ) u_scan (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .running     (running),
    .x           (x),
    .y           (y),
    .h_region    (h_region),
    .v_region    (v_region),
    .frame_start (frame_start)
  );

  // the request window is the active window shifted left by the fetch latency
  assign x_lead    = {1'b0, x} + LEAD;
  assign line_on   = running && (v_region == REG_ACTIVE);
  assign pix_on    = line_on && (h_region == REG_ACTIVE);
  assign data_req  = line_on && (x_lead >= REQ_LO) && (x_lead < REQ_HI);
  assign data_lock = line_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hsync  <= !HS_POL;
      vga_vsync  <= !VS_POL;
      vga_de     <= 1'b0;
      pixel_x    <= '0;
      pixel_y    <= '0;
      vga_red    <= '0;
      vga_green  <= '0;
      vga_blue   <= '0;
      frame_sync <= 1'b0;
      fs_cnt     <= '0;
      underflow  <= 1'b0;
    end else if (!running) begin
      vga_hsync  <= !HS_POL;
      vga_vsync  <= !VS_POL;
      vga_de     <= 1'b0;
      pixel_x    <= '0;
      pixel_y    <= '0;
      vga_red    <= '0;
      vga_green  <= '0;
      vga_blue   <= '0;
      frame_sync <= 1'b0;
      fs_cnt     <= '0;
      underflow  <= 1'b0;
    end else begin
      vga_hsync <= (h_region == REG_SYNC) ? HS_POL : !HS_POL;
      vga_vsync <= (v_region == REG_SYNC) ? VS_POL : !VS_POL;
      vga_de    <= pix_on;
      pixel_x   <= pix_on ? (x - X0) : '0;
      pixel_y   <= pix_on ? (y - Y0) : '0;
      if (pix_on && din_valid) {vga_blue, vga_green, vga_red} <= din;
      else                     {vga_blue, vga_green, vga_red} <= '0;

      if (frame_start) begin
        frame_sync <= 1'b1;
        fs_cnt     <= FS_LOAD;
      end else if (fs_cnt != '0) begin
        frame_sync <= 1'b1;
        fs_cnt     <= fs_cnt - 1'b1;
      end else begin
        frame_sync <= 1'b0;
      end

      // a missed pixel outranks the frame-start clear
      if (pix_on && !din_valid) underflow <= 1'b1;
      else if (frame_start)     underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_engine.sv
// tb/tb_vga_timing_engine.sv - randomized check of two engine builds against a frame-position model
module tb_vga_timing_engine;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int TOT = HT * VT;
  localparam int XA = HS + HB;
  localparam int YA = VS + VB;
  localparam int RW = 5, GW = 6, BW = 5;
  localparam int PW = RW + GW + BW;
  localparam int XW = $clog2(HT);
  localparam int YW = $clog2(VT);
  localparam int FS = 4;
  localparam int N_CYC = 3000;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic [1:0][PW-1:0] din;
  logic [1:0]         din_valid;
  logic [1:0]         data_req, frame_sync, data_lock, underflow;
  logic [1:0]         vga_hsync, vga_vsync, vga_de;
  logic [1:0][XW-1:0] pixel_x;
  logic [1:0][YW-1:0] pixel_y;
  logic [1:0][RW-1:0] vga_red;
  logic [1:0][GW-1:0] vga_green;
  logic [1:0][BW-1:0] vga_blue;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    vga_timing_engine #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .HS_POL   (g == 1), .VS_POL (g == 1),
      .R_W (RW), .G_W (GW), .B_W (BW),
      .REQ_LEAD (g == 0 ? 1 : 3),
      .FSYNC_CYC (FS)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .din        (din[g]),
      .din_valid  (din_valid[g]),
      .data_req   (data_req[g]),
      .frame_sync (frame_sync[g]),
      .data_lock  (data_lock[g]),
      .underflow  (underflow[g]),
      .vga_hsync  (vga_hsync[g]),
      .vga_vsync  (vga_vsync[g]),
      .vga_de     (vga_de[g]),
      .pixel_x    (pixel_x[g]),
      .pixel_y    (pixel_y[g]),
      .vga_red    (vga_red[g]),
      .vga_green  (vga_green[g]),
      .vga_blue   (vga_blue[g])
    );
  end

  int n_vec;
  int n_err;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // model: frame position t = y*HT + x, plus the registered outputs expected after the last edge
  bit m_run;
  int m_t;
  int e_hs[2], e_vs[2], e_de[2], e_px[2], e_py[2], e_rgb[2], e_fs[2], e_uf[2];
  logic [1:0][7:0] hist;

  function automatic int lead_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic int pol_of(input int g);
    return (g == 1) ? 1 : 0;
  endfunction

  function automatic bit y_active();
    int y = m_t / HT;
    return m_run && (y >= YA) && (y < YA + VA);
  endfunction

  function automatic bit exp_req(input int g);
    int xl = (m_t % HT) + lead_of(g);
    return y_active() && (xl >= XA) && (xl < XA + HA);
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_t   = 0;
    for (int g = 0; g < 2; g++) begin
      e_hs[g] = 1 - pol_of(g); e_vs[g] = 1 - pol_of(g);
      e_de[g] = 0; e_px[g] = 0; e_py[g] = 0; e_rgb[g] = 0; e_fs[g] = 0; e_uf[g] = 0;
    end
  endtask

  task automatic model_step();
    int  x, y;
    bit  act;
    if (!rst_n) begin
      model_reset();
      return;
    end
    x   = m_t % HT;
    y   = m_t / HT;
    act = m_run && (x >= XA) && (x < XA + HA) && (y >= YA) && (y < YA + VA);
    for (int g = 0; g < 2; g++) begin
      e_hs[g]  = (m_run && x < HS) ? pol_of(g) : 1 - pol_of(g);
      e_vs[g]  = (m_run && y < VS) ? pol_of(g) : 1 - pol_of(g);
      e_de[g]  = act ? 1 : 0;
      e_px[g]  = act ? x - XA : 0;
      e_py[g]  = act ? y - YA : 0;
      e_rgb[g] = (act && din_valid[g]) ? int'(din[g]) : 0;
      e_fs[g]  = (m_run && m_t < FS) ? 1 : 0;
      if (!m_run)                   e_uf[g] = 0;
      else if (act && !din_valid[g]) e_uf[g] = 1;
      else if (m_t == 0)             e_uf[g] = 0;
    end
    if (!m_run) begin
      m_run = en;
      m_t   = 0;
    end else if (m_t == TOT - 1) begin
      m_run = en;
      m_t   = 0;
    end else begin
      m_t++;
    end
  endtask

  task automatic check_cycle();
    for (int g = 0; g < 2; g++) begin
      check_val($sformatf("d%0d.hsync", g),      32'(vga_hsync[g]),  32'(e_hs[g]));
      check_val($sformatf("d%0d.vsync", g),      32'(vga_vsync[g]),  32'(e_vs[g]));
      check_val($sformatf("d%0d.de", g),         32'(vga_de[g]),     32'(e_de[g]));
      check_val($sformatf("d%0d.pixel_x", g),    32'(pixel_x[g]),    32'(e_px[g]));
      check_val($sformatf("d%0d.pixel_y", g),    32'(pixel_y[g]),    32'(e_py[g]));
      check_val($sformatf("d%0d.rgb", g),
                32'({vga_blue[g], vga_green[g], vga_red[g]}),        32'(e_rgb[g]));
      check_val($sformatf("d%0d.frame_sync", g), 32'(frame_sync[g]), 32'(e_fs[g]));
      check_val($sformatf("d%0d.underflow", g),  32'(underflow[g]),  32'(e_uf[g]));
      check_val($sformatf("d%0d.data_req", g),   32'(data_req[g]),   32'(exp_req(g)));
      check_val($sformatf("d%0d.data_lock", g),  32'(data_lock[g]),  32'(y_active()));
    end
  endtask

  // fetcher answers each request exactly REQ_LEAD clocks later, occasionally failing to
  task automatic drive_inputs();
    if ($urandom_range(0, 99) == 0) en = !en;
    for (int g = 0; g < 2; g++) begin
      hist[g]      = {hist[g][6:0], exp_req(g)};
      din_valid[g] = hist[g][lead_of(g)] && ($urandom_range(0, 39) != 0);
      din[g]       = PW'($urandom);
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    en        = 1'b0;
    din       = '0;
    din_valid = '0;
    hist      = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cycle();
    rst_n = 1'b1;
    en    = 1'b1;
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_cycle();
      if (!rst_n) begin
        rst_n = 1'b1;
        en    = 1'b1;
      end
      drive_inputs();
      if (cyc == 1517 || cyc == 2403) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_cycle();
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
